alu_exec_unit: RTL and testbench

Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder. It latches operands and the code on a start strobe and executes the operation. Logic and arithmetic ops complete in one cycle; SLL/SRL run as an iterative 1-bit-per-cycle shifter, so the datapath can reuse a small barrel-free shifter. It sits between the control decoder and the register-file writeback stage, and reports completion with a done pulse.

---
 rtl/alu_exec_if.sv | 28 ++
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control decoder side (master)
// and the execution unit (slave).
interface alu_exec_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [3:0]         ALU_input;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic               ovf;
  logic               illegal;

  modport master (
    output start, ALU_input, a, b, shamt,
    input  busy, done, result, zero, ovf, illegal
  );

  modport slave (
    input  start, ALU_input, a, b, shamt,
    output busy, done, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops, iterative
// 1-bit-per-cycle SLL/SRL, registered result and flags, done pulse.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_exec_if.slave   bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;

  // EXEC is the one-cycle slot between accept and commit for non-shift ops.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;
  logic [WIDTH-1:0]   alu_sum;
  logic [WIDTH-1:0]   alu_diff;
  logic [WIDTH-1:0]   work_next;

  // Single-cycle ALU on the latched operands.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    alu_sum  = a_q + b_q;
    alu_diff = a_q - b_q;
    unique case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_ADD: begin
        alu_res = alu_sum;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = alu_diff;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_NOR: alu_res = ~(a_q | b_q);
      // Only zero-length shifts reach the single-cycle path.
      OP_SLL, OP_SRL: alu_res = b_q;
      default: alu_ill = 1'b1;
    endcase
  end

  // One-bit zero-filled shift step for the working register.
  always_comb begin
    work_next = (op_q == OP_SLL) ? {work_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, work_q[WIDTH-1:1]};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          op_d   = bus.ALU_input;
          a_d    = bus.a;
          b_d    = bus.b;
          work_d = bus.b;
          cnt_d  = bus.shamt;
          if ((bus.ALU_input == OP_SLL || bus.ALU_input == OP_SRL) && bus.shamt != '0)
            state_d = S_SHIFT;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        ovf_d     = alu_ovf;
        illegal_d = alu_ill;
        state_d   = S_DONE;
      end
      S_SHIFT: begin
        work_d = work_next;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d  = work_next;
          zero_d    = (work_next == '0);
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy    = (state_q == S_SHIFT);
  assign bus.done    = (state_q == S_DONE);
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.ovf     = ovf_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus
// randomized ops compared against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W  = 32;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] last_res = '0;

  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

  alu_exec_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation semantics.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [SW-1:0] sh, output logic [W-1:0] r,
                                output logic o, output logic il);
    longint sa, sb, wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = 1'b0;
    il = 1'b0;
    r  = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        wide = sa + sb;
        r = wide[W-1:0];
        o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd3: begin
        wide = sa - sb;
        r = wide[W-1:0];
        o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: r = ~(a | b);
      4'd8: r = b << sh;
      4'd9: r = b >> sh;
      default: il = 1'b1;
    endcase
  endfunction

  // Issue one op, wait for done (bounded), check latency, busy length,
  // result hold during shift, result/flags, and a one-cycle done pulse.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] sh, input bit inject);
    logic [W-1:0] r;
    logic o, il;
    int lat, bcnt, exp_lat, exp_busy;
    bit is_shift;
    model(op, a, b, sh, r, o, il);
    is_shift = (op == 4'd8 || op == 4'd9) && (sh != 0);
    exp_lat  = is_shift ? int'(sh) : 1;
    exp_busy = is_shift ? int'(sh) : 0;

    @(negedge clk);
    bus.start = 1'b1; bus.ALU_input = op; bus.a = a; bus.b = b; bus.shamt = sh;
    @(negedge clk);
    lat = 0; bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) begin
        bcnt++;
        check({tag, "_hold"}, bus.result, last_res);
      end
      if (inject && bus.busy) begin
        bus.start = 1'b1; bus.ALU_input = 4'($urandom);
        bus.a = $urandom; bus.b = $urandom; bus.shamt = SW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "_done"},    W'(bus.done),    W'(1));
    check({tag, "_latency"}, W'(lat),         W'(exp_lat));
    check({tag, "_busy"},    W'(bcnt),        W'(exp_busy));
    check({tag, "_result"},  bus.result,      r);
    check({tag, "_zero"},    W'(bus.zero),    W'(r == '0));
    check({tag, "_ovf"},     W'(bus.ovf),     W'(o));
    check({tag, "_illegal"}, W'(bus.illegal), W'(il));
    @(negedge clk);
    check({tag, "_pulse"},   W'(bus.done),    W'(0));
    check({tag, "_held"},    bus.result,      r);
    last_res = r;
  endtask

  initial begin
    logic [3:0] legal [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
    logic [3:0] op;
    logic [W-1:0] ra, rb;
    int seen;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.ALU_input = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
    #3;
    check("rst_busy",    W'(bus.busy),    W'(0));
    check("rst_done",    W'(bus.done),    W'(0));
    check("rst_result",  bus.result,      W'(0));
    check("rst_flags",   {29'd0, bus.zero, bus.ovf, bus.illegal}, W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op("add_ovf",  4'd2, 32'h7FFF_FFFF, 32'h1, '0, 0);
    run_op("sub_zero", 4'd3, 32'd5, 32'd5, '0, 0);
    run_op("slt_neg",  4'd4, 32'hFFFF_FFFF, 32'h1, '0, 0);
    run_op("slt_pos",  4'd4, 32'h1, 32'hFFFF_FFFF, '0, 0);
    run_op("nor_zero", 4'd5, 32'h0, 32'h0, '0, 0);
    run_op("sll_31",   4'd8, 32'h0, 32'h1, 5'd31, 1);
    run_op("srl_4",    4'd9, 32'h0, 32'h8000_0000, 5'd4, 0);
    run_op("srl_0",    4'd9, 32'h0, 32'h1234, 5'd0, 0);

    // Back-to-back: start held high across an AND and an illegal code.
    @(negedge clk);
    bus.start = 1'b1; bus.ALU_input = 4'd0; bus.a = 32'hF0F0; bus.b = 32'h0FF0; bus.shamt = '0;
    @(negedge clk);
    bus.ALU_input = 4'b0111; bus.a = 32'hFFFF; bus.b = 32'h1;
    @(negedge clk);
    check("b2b_done1",   W'(bus.done),    W'(1));
    check("b2b_res1",    bus.result,      32'h00F0);
    check("b2b_ill1",    W'(bus.illegal), W'(0));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_gap",     W'(bus.done),    W'(0));
    @(negedge clk);
    check("b2b_done2",   W'(bus.done),    W'(1));
    check("b2b_res2",    bus.result,      W'(0));
    check("b2b_ill2",    W'(bus.illegal), W'(1));
    check("b2b_zero2",   W'(bus.zero),    W'(1));
    check("b2b_ovf2",    W'(bus.ovf),     W'(0));
    last_res = '0;

    // Randomized ops.
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legal[$urandom_range(0, 7)];
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'h8000_0000;
        2: rb = ra;
        default: ;
      endcase
      run_op("rand", op, ra, rb, SW'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of a long shift.
    run_op("pre_rst", 4'd2, 32'd1, 32'd1, '0, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.ALU_input = 4'd8; bus.a = '0; bus.b = 32'h5; bus.shamt = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy",     W'(bus.busy),    W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", W'(bus.busy),    W'(0));
    check("mid_rst_done", W'(bus.done),    W'(0));
    check("mid_rst_res",  bus.result,      W'(0));
    check("mid_rst_flags", {29'd0, bus.zero, bus.ovf, bus.illegal}, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("no_done_after_rst", W'(seen), W'(0));
    last_res = '0;
    run_op("post_rst", 4'd1, 32'hA5, 32'h5A00, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
